// File: rtl/tracking_engine_pkg.sv
// rtl/tracking_engine_pkg.sv - shared tracking-engine constants and noncoherent FSM encodings
package tracking_engine_pkg;

  localparam int NONCOH_DATA_WIDTH = 16;
  localparam int NONCOH_ACC_WIDTH  = 24;
  localparam int NONCOH_CORR_NUM   = 8;
  localparam int NONCOH_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    NONCOH_STATE_ACC  = 2'd0,
    NONCOH_STATE_SCAN = 2'd1,
    NONCOH_STATE_DONE = 2'd2
  } noncoh_state_e;

  function automatic int noncoh_idx_width(input int corr_num);
    return (corr_num > 1) ? $clog2(corr_num) : 1;
  endfunction

endpackage

// File: rtl/noncoh_peak_acc_if.sv
// rtl/noncoh_peak_acc_if.sv - amplitude input stream and peak result bundle
interface noncoh_peak_acc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int IDX_WIDTH  = 3
) ();
  logic                  amp_valid;
  logic [DATA_WIDTH-1:0] amp_data;
  logic                  peak_valid;
  logic [ACC_WIDTH-1:0]  peak_value;
  logic [IDX_WIDTH-1:0]  peak_index;

  modport master (output amp_valid, amp_data, input peak_valid, peak_value, peak_index);
  modport slave  (input amp_valid, amp_data, output peak_valid, peak_value, peak_index);
endinterface

// File: rtl/noncoh_bin_array.sv
// rtl/noncoh_bin_array.sv - per-bin accumulators with load/add write port and scan read port
// Saturating add when NONCOH_SAT_EN is defined, modulo wrap otherwise.
module noncoh_bin_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int CORR_NUM   = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wr_en,
  input  logic                  wr_load,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [ACC_WIDTH-1:0]  rd_data
);

  logic [ACC_WIDTH-1:0] acc_q [CORR_NUM];
  logic [ACC_WIDTH:0]   sum_full;
  logic [ACC_WIDTH-1:0] sum;

  assign sum_full = {1'b0, acc_q[wr_addr]} + (ACC_WIDTH+1)'(wr_data);

`ifdef NONCOH_SAT_EN
  assign sum = sum_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
`else
  assign sum = sum_full[ACC_WIDTH-1:0];
`endif

  assign rd_data = acc_q[rd_addr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < CORR_NUM; i++) acc_q[i] <= '0;
    end else if (wr_en) begin
      acc_q[wr_addr] <= wr_load ? ACC_WIDTH'(wr_data) : sum;
    end
  end

endmodule

// File: rtl/noncoh_peak_acc.sv
// rtl/noncoh_peak_acc.sv - noncoherent bin accumulator with peak scan (NONCOH_SAT_EN selects saturating sums)
module noncoh_peak_acc
  import tracking_engine_pkg::*;
#(
  parameter int DATA_WIDTH = NONCOH_DATA_WIDTH,
  parameter int ACC_WIDTH  = NONCOH_ACC_WIDTH,
  parameter int CORR_NUM   = NONCOH_CORR_NUM,
  parameter int CNT_WIDTH  = NONCOH_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] noncoh_num,
  output logic                 busy_scan,
  output logic                 overrun,
  noncoh_peak_acc_if.slave     amp_if
);

  localparam int                IDX_W    = noncoh_idx_width(CORR_NUM);
  localparam logic [IDX_W-1:0]  LAST_BIN = IDX_W'(CORR_NUM - 1);

  noncoh_state_e        state_q, state_d;
  logic [IDX_W-1:0]     bin_cnt;
  logic [CNT_WIDTH-1:0] epoch_cnt, num_lat, last_epoch;
  logic                 amp_valid, accept, last_sample, scan_last, take_new;
  logic [ACC_WIDTH-1:0] rd_data, best_val, next_best, peak_value_q;
  logic [IDX_W-1:0]     best_idx, next_idx, peak_index_q;
  logic                 peak_valid_q, overrun_q;

  assign amp_valid   = amp_if.amp_valid;
  assign last_epoch  = (num_lat == '0) ? '0 : num_lat - CNT_WIDTH'(1);
  assign last_sample = (bin_cnt == LAST_BIN) && (epoch_cnt == last_epoch);
  assign scan_last   = (state_q == NONCOH_STATE_SCAN) && (bin_cnt == LAST_BIN);
  // Strict greater-than keeps the lowest index on ties.
  assign take_new    = (bin_cnt == '0) || (rd_data > best_val);
  assign next_best   = take_new ? rd_data : best_val;
  assign next_idx    = take_new ? bin_cnt : best_idx;

  noncoh_bin_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .CORR_NUM   (CORR_NUM),
    .IDX_W      (IDX_W)
  ) u_bins (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (accept),
    .wr_load (epoch_cnt == '0),
    .wr_addr (bin_cnt),
    .wr_data (amp_if.amp_data),
    .rd_addr (bin_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= NONCOH_STATE_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    busy_scan = 1'b0;
    case (state_q)
      NONCOH_STATE_ACC: begin
        accept = amp_valid && !clear;
        if (accept && last_sample) state_d = NONCOH_STATE_SCAN;
      end
      NONCOH_STATE_SCAN: begin
        busy_scan = 1'b1;
        if (scan_last) state_d = NONCOH_STATE_DONE;
      end
      NONCOH_STATE_DONE: state_d = NONCOH_STATE_ACC;
      default:           state_d = NONCOH_STATE_ACC;
    endcase
    if (clear) state_d = NONCOH_STATE_ACC;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bin_cnt      <= '0;
      epoch_cnt    <= '0;
      num_lat      <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      peak_valid_q <= 1'b0;
      peak_value_q <= '0;
      peak_index_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (clear) begin
        bin_cnt   <= '0;
        epoch_cnt <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (amp_valid && state_q != NONCOH_STATE_ACC) overrun_q <= 1'b1;
        case (state_q)
          NONCOH_STATE_ACC: begin
            if (bin_cnt == '0 && epoch_cnt == '0) num_lat <= noncoh_num;
            if (amp_valid) begin
              if (bin_cnt == LAST_BIN) begin
                bin_cnt   <= '0;
                epoch_cnt <= last_sample ? '0 : epoch_cnt + CNT_WIDTH'(1);
              end else begin
                bin_cnt <= bin_cnt + IDX_W'(1);
              end
            end
          end
          NONCOH_STATE_SCAN: begin
            best_val <= next_best;
            best_idx <= next_idx;
            if (scan_last) begin
              bin_cnt      <= '0;
              peak_valid_q <= 1'b1;
              peak_value_q <= next_best;
              peak_index_q <= next_idx;
            end else begin
              bin_cnt <= bin_cnt + IDX_W'(1);
            end
          end
          NONCOH_STATE_DONE: begin
            bin_cnt   <= '0;
            epoch_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign overrun           = overrun_q;
  assign amp_if.peak_valid = peak_valid_q;
  assign amp_if.peak_value = peak_value_q;
  assign amp_if.peak_index = peak_index_q;

endmodule

// File: tb/tb_noncoh_peak_acc.sv
// tb/tb_noncoh_peak_acc.sv - scoreboard bench for noncoh_peak_acc (24-bit and 16-bit accumulator instances)
module tb_noncoh_peak_acc;

  typedef struct packed {
    logic [23:0] value;
    logic [2:0]  idx;
  } exp_t;

`ifdef NONCOH_SAT_EN
  localparam logic [23:0] SAT_EXP = 24'h00FFFF;
`else
  localparam logic [23:0] SAT_EXP = 24'h00FFFE;
`endif

  logic       clk = 1'b0;
  logic       rst_b, clear, s_clear;
  logic [7:0] noncoh_num, s_noncoh;
  logic       busy_scan, overrun, s_busy, s_overrun;
  exp_t       sb[$];
  exp_t       ex;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  noncoh_peak_acc_if #(.DATA_WIDTH(16), .ACC_WIDTH(24), .IDX_WIDTH(3)) m_if ();
  noncoh_peak_acc_if #(.DATA_WIDTH(16), .ACC_WIDTH(16), .IDX_WIDTH(3)) s_if ();

  noncoh_peak_acc #(.DATA_WIDTH(16), .ACC_WIDTH(24), .CORR_NUM(8), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .noncoh_num(noncoh_num),
    .busy_scan(busy_scan), .overrun(overrun), .amp_if(m_if.slave));

  noncoh_peak_acc #(.DATA_WIDTH(16), .ACC_WIDTH(16), .CORR_NUM(8), .CNT_WIDTH(8)) u_sat (
    .clk(clk), .rst_b(rst_b), .clear(s_clear), .noncoh_num(s_noncoh),
    .busy_scan(s_busy), .overrun(s_overrun), .amp_if(s_if.slave));

  function automatic exp_t model(input int unsigned s[8]);
    exp_t        e;
    int unsigned best = s[0];
    int          bi = 0;
    for (int i = 1; i < 8; i++) if (s[i] > best) begin best = s[i]; bi = i; end
    e.value = 24'(best);
    e.idx   = 3'(bi);
    return e;
  endfunction

  task automatic drive(input bit sel, input logic [15:0] v);
    @(negedge clk);
    if (sel) begin s_if.amp_valid = 1'b1; s_if.amp_data = v; end
    else     begin m_if.amp_valid = 1'b1; m_if.amp_data = v; end
  endtask

  task automatic idle();
    @(negedge clk);
    m_if.amp_valid = 1'b0;
    s_if.amp_valid = 1'b0;
  endtask

  task automatic wait_peak(input bit sel, output bit seen, output int lat);
    seen = 1'b0;
    lat  = 1;
    while (!seen && lat < 40) begin
      if ((sel ? s_if.peak_valid : m_if.peak_valid) === 1'b1) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (m_if.peak_valid !== 1'b0) begin n_err++; $display("FAIL reset_peak_valid got %0b want 0", m_if.peak_valid); end
    n_cmp++; if (m_if.peak_value !== 24'd0) begin n_err++; $display("FAIL reset_peak_value got %0d want 0", m_if.peak_value); end
    n_cmp++; if (m_if.peak_index !== 3'd0) begin n_err++; $display("FAIL reset_peak_index got %0d want 0", m_if.peak_index); end
    n_cmp++; if ({busy_scan, overrun} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {busy_scan, overrun}); end
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy_scan !== 1'b0) begin n_err++; $display("FAIL idle_busy_scan got %0b want 0", busy_scan); end
  endtask

  task automatic test_single_epoch();
    int unsigned a[8];
    bit seen; int lat;
    a = '{10, 20, 90, 30, 0, 0, 0, 5};
    noncoh_num = 8'd1;
    sb.push_back(model(a));
    for (int i = 0; i < 8; i++) drive(0, 16'(a[i]));
    idle();
    n_cmp++; if (busy_scan !== 1'b1) begin n_err++; $display("FAIL single_busy_scan got %0b want 1", busy_scan); end
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen) begin n_err++; $display("FAIL single_timeout got no peak_valid want pulse"); end
    n_cmp++; if (lat != 9) begin n_err++; $display("FAIL single_latency got %0d want 9", lat); end
    n_cmp++; if (m_if.peak_index !== ex.idx) begin n_err++; $display("FAIL single_index got %0d want %0d", m_if.peak_index, ex.idx); end
    n_cmp++; if (m_if.peak_value !== ex.value) begin n_err++; $display("FAIL single_value got %0d want %0d", m_if.peak_value, ex.value); end
    @(negedge clk);
    n_cmp++; if (m_if.peak_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got %0b want 0", m_if.peak_valid); end
    n_cmp++; if (m_if.peak_value !== ex.value) begin n_err++; $display("FAIL single_hold got %0d want %0d", m_if.peak_value, ex.value); end
  endtask

  task automatic test_four_epoch();
    int unsigned s[8];
    bit seen; int lat;
    noncoh_num = 8'd4;
    for (int i = 0; i < 8; i++) s[i] = (i == 5) ? 4000 : 400;
    sb.push_back(model(s));
    for (int e = 0; e < 4; e++)
      for (int b = 0; b < 8; b++) begin
        drive(0, (b == 5) ? 16'd1000 : 16'd100);
        if (e == 0 && b == 1) noncoh_num = 8'd1;
      end
    idle();
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen || lat != 9) begin n_err++; $display("FAIL four_latency got seen=%0b lat=%0d want 1/9", seen, lat); end
    n_cmp++; if (m_if.peak_index !== ex.idx) begin n_err++; $display("FAIL four_index got %0d want %0d", m_if.peak_index, ex.idx); end
    n_cmp++; if (m_if.peak_value !== ex.value) begin n_err++; $display("FAIL four_value got %0d want %0d", m_if.peak_value, ex.value); end
  endtask

  task automatic test_tie();
    int unsigned s[8];
    bit seen; int lat;
    noncoh_num = 8'd3;
    for (int i = 0; i < 8; i++) s[i] = 21;
    sb.push_back(model(s));
    for (int k = 0; k < 24; k++) drive(0, 16'd7);
    idle();
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen) begin n_err++; $display("FAIL tie_timeout got no peak_valid want pulse"); end
    n_cmp++; if (m_if.peak_index !== ex.idx) begin n_err++; $display("FAIL tie_index got %0d want %0d", m_if.peak_index, ex.idx); end
    n_cmp++; if (m_if.peak_value !== ex.value) begin n_err++; $display("FAIL tie_value got %0d want %0d", m_if.peak_value, ex.value); end
  endtask

  task automatic test_overrun_clear();
    int unsigned a[8];
    bit seen; int lat;
    logic [23:0] held;
    a = '{3, 1, 4, 1, 5, 9, 2, 6};
    noncoh_num = 8'd1;
    sb.push_back(model(a));
    for (int i = 0; i < 8; i++) drive(0, 16'(a[i]));
    drive(0, 16'hFFFF);
    idle();
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set got %0b want 1", overrun); end
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen || m_if.peak_value !== ex.value || m_if.peak_index !== ex.idx) begin
      n_err++; $display("FAIL overrun_result got %0d@%0d want %0d@%0d", m_if.peak_value, m_if.peak_index, ex.value, ex.idx); end
    held = ex.value;
    @(negedge clk);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky got %0b want 1", overrun); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear got %0b want 0", overrun); end

    noncoh_num = 8'd3;
    for (int k = 0; k < 19; k++) drive(0, 16'd500);
    @(negedge clk);
    m_if.amp_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_if.peak_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL clear_no_pulse got peak_valid want none"); end
    n_cmp++; if (m_if.peak_value !== held) begin n_err++; $display("FAIL clear_hold got %0d want %0d", m_if.peak_value, held); end
  endtask

  task automatic test_fresh_after_clear();
    int unsigned s[8];
    int unsigned v;
    bit seen; int lat;
    noncoh_num = 8'd2;
    for (int i = 0; i < 8; i++) s[i] = 0;
    for (int e = 0; e < 2; e++)
      for (int b = 0; b < 8; b++) begin
        v = $urandom_range(0, 1000);
        s[b] += v;
      end
    sb.push_back(model(s));
    for (int e = 0; e < 2; e++)
      for (int b = 0; b < 8; b++) drive(0, 16'(e == 0 ? s[b] / 2 : s[b] - s[b] / 2));
    idle();
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen || lat != 9) begin n_err++; $display("FAIL fresh_latency got seen=%0b lat=%0d want 1/9", seen, lat); end
    n_cmp++; if (m_if.peak_value !== ex.value || m_if.peak_index !== ex.idx) begin
      n_err++; $display("FAIL fresh_result got %0d@%0d want %0d@%0d", m_if.peak_value, m_if.peak_index, ex.value, ex.idx); end
  endtask

  task automatic test_saturation();
    bit seen; int lat;
    s_noncoh = 8'd2;
    ex.value = SAT_EXP;
    ex.idx   = 3'd0;
    sb.push_back(ex);
    for (int k = 0; k < 16; k++) drive(1, 16'hFFFF);
    idle();
    wait_peak(1, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen || lat != 9) begin n_err++; $display("FAIL sat_latency got seen=%0b lat=%0d want 1/9", seen, lat); end
    n_cmp++; if (s_if.peak_value !== ex.value[15:0]) begin n_err++; $display("FAIL sat_value got %0h want %0h", s_if.peak_value, ex.value[15:0]); end
    n_cmp++; if (s_if.peak_index !== ex.idx) begin n_err++; $display("FAIL sat_index got %0d want %0d", s_if.peak_index, ex.idx); end
  endtask

  task automatic test_reset_mid_scan();
    int unsigned a[8];
    bit seen; int lat;
    noncoh_num = 8'd1;
    for (int i = 0; i < 8; i++) drive(0, 16'(100 + i));
    idle();
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_cmp++; if ({busy_scan, overrun, m_if.peak_valid} !== 3'b000) begin n_err++; $display("FAIL rst_scan_flags got %b want 000", {busy_scan, overrun, m_if.peak_valid}); end
    n_cmp++; if (m_if.peak_value !== 24'd0 || m_if.peak_index !== 3'd0) begin
      n_err++; $display("FAIL rst_scan_peak got %0d@%0d want 0@0", m_if.peak_value, m_if.peak_index); end
    @(negedge clk);
    rst_b = 1'b1;
    noncoh_num = 8'd0;
    @(negedge clk);
    a = '{5, 50, 7, 50, 1, 0, 0, 0};
    sb.push_back(model(a));
    for (int i = 0; i < 8; i++) drive(0, 16'(a[i]));
    idle();
    wait_peak(0, seen, lat);
    ex = sb.pop_front();
    n_cmp++; if (!seen || lat != 9) begin n_err++; $display("FAIL zero_num_latency got seen=%0b lat=%0d want 1/9", seen, lat); end
    n_cmp++; if (m_if.peak_value !== ex.value || m_if.peak_index !== ex.idx) begin
      n_err++; $display("FAIL zero_num_result got %0d@%0d want %0d@%0d", m_if.peak_value, m_if.peak_index, ex.value, ex.idx); end
  endtask

  initial begin
    rst_b = 1'b0; clear = 1'b0; s_clear = 1'b0;
    noncoh_num = 8'd1; s_noncoh = 8'd1;
    m_if.amp_valid = 1'b0; m_if.amp_data = '0;
    s_if.amp_valid = 1'b0; s_if.amp_data = '0;
    test_reset();
    test_single_epoch();
    test_four_epoch();
    test_tie();
    test_overrun_clear();
    test_fresh_after_clear();
    test_saturation();
    test_reset_mid_scan();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
